sample_tick_scheduler: RTL and testbench
========================================

SAMPLE_TICK_SCHEDULER -- requirements
Module: sample_tick_scheduler

Interface
REQ-001 SHALL have parameter DIV_W, default 16, meaning width of the divisor field and the period counter.
REQ-002 SHALL have parameter CNT_W, default 12, meaning width of the burst-length field and the tick counter.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning the reset: asynchronous assert, active-low.
REQ-005 SHALL have port cfg_valid, input, 1, meaning the requester offers a burst configuration.
REQ-006 SHALL have port cfg_ready, output, 1, meaning the block accepts a configuration this cycle.
REQ-007 SHALL have port cfg_div, input, DIV_W, meaning the clk cycles per sample period.
REQ-008 SHALL have port cfg_len, input, CNT_W, meaning the ticks per burst; 0 means continuous.
REQ-009 SHALL have port stop, input, 1, meaning the requester asks for a graceful burst stop.
REQ-010 SHALL have port sclk, output, 1, meaning the generated sample clock.
REQ-011 SHALL have port tick, output, 1, meaning a one-cycle strobe at the end of each sample period.
REQ-012 SHALL have port tick_count, output, CNT_W, meaning the ticks issued in the current or last burst.
REQ-013 SHALL have port busy, output, 1, meaning the FSM is not IDLE.
REQ-014 SHALL have port done, output, 1, meaning a one-cycle pulse when a burst ends.

Function
REQ-015 SHALL implement the FSM states IDLE, RUN and DONE, each as a registered state.
REQ-016 SHALL drive cfg_ready=1 only in IDLE; a handshake is cfg_valid&&cfg_ready on a rising edge.
REQ-017 SHALL, on handshake, latch div=max(cfg_div,2) and len=cfg_len, clear the period counter and tick_count, and enter RUN.
REQ-018 SHALL keep latched div/len constant for the whole burst; cfg_* changes during RUN have no effect.
REQ-019 SHALL, in RUN, count the period counter 0..div-1 and wrap it to 0 after div-1.
REQ-020 SHALL assert tick for exactly one cycle when the counter equals div-1, with the first tick div cycles after the handshake edge.
REQ-021 SHALL increment tick_count on each tick, wrapping modulo 2^CNT_W when len=0.
REQ-022 SHALL drive sclk low while counter < div>>1 and high otherwise in RUN, and hold it low in IDLE and DONE.
REQ-023 SHALL move RUN->DONE on the tick where tick_count reaches len (len!=0).
REQ-024 SHALL, on stop asserted in RUN, set a sticky stop-pending flag and move RUN->DONE on the next tick; the in-progress period always completes.
REQ-025 SHALL treat stop coincident with a tick as taking effect on that tick.
REQ-026 SHALL produce a single DONE when stop and the final len tick coincide.
REQ-027 SHALL ignore stop in IDLE and DONE and clear the stop-pending flag on entering DONE.
REQ-028 SHALL pulse done for the single DONE cycle, then return to IDLE.
REQ-029 SHALL hold tick_count after DONE until the next handshake.
REQ-030 SHALL drive busy=1 in RUN and DONE.
REQ-031 SHALL make a handshake possible in the cycle after done, with no dead cycle beyond DONE.

Reset
REQ-032 SHALL, while rst_n=0, immediately force state IDLE, counters 0, stop-pending 0, div=2, len=0.
REQ-033 SHALL, while rst_n=0, drive sclk=0, tick=0, done=0, busy=0, tick_count=0 and cfg_ready=0.
REQ-034 SHALL set cfg_ready=1 on the first rising clk edge after rst_n deasserts, in IDLE.
REQ-035 SHALL abort a burst when reset is asserted mid-burst, with no done pulse.

Verification
REQ-036 SHALL cover: cfg_div=4, cfg_len=3 -> ticks 4, 8 and 12 cycles after the handshake; sclk 0,0,1,1 per period; done 1 cycle after the third tick; tick_count=3.
REQ-037 SHALL cover: cfg_div=0 and cfg_div=1 -> behaves as div=2, with a tick every 2 cycles and sclk toggling each cycle.
REQ-038 SHALL cover: cfg_div=10, cfg_len=0, stop pulsed at cycle 25 -> ticks at cycles 10, 20 and 30, then done; tick_count=3.
REQ-039 SHALL cover: cfg_len=2 with stop on the second tick cycle -> exactly one done pulse and tick_count=2.
REQ-040 SHALL cover: rst_n low at cycle 7 of a div=5 burst -> all outputs 0 at once, no done pulse, cfg_ready=1 on the first clk edge after release.
REQ-041 SHALL cover: back-to-back bursts with cfg_valid held high -> a second handshake in the cycle after done, and cfg_div changes mid-burst ignored.

Source files
------------

// File: rtl/sample_tick_scheduler_if.sv
// Configuration handshake and sample-clock outputs of the sample tick scheduler.
// The requester side uses the master modport; the scheduler uses the slave modport.
interface sample_tick_scheduler_if #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 12
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_len;
    logic             stop;
    logic             sclk;
    logic             tick;
    logic [CNT_W-1:0] tick_count;
    logic             busy;
    logic             done;

    modport master (
        output cfg_valid, cfg_div, cfg_len, stop,
        input  cfg_ready, sclk, tick, tick_count, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_div, cfg_len, stop,
        output cfg_ready, sclk, tick, tick_count, busy, done
    );
endinterface

// File: rtl/sample_tick_scheduler.sv
// Generates bursts of sample periods: a divided sample clock, a per-period tick strobe,
// a tick counter and a done pulse, with graceful stop and continuous (len=0) mode.
module sample_tick_scheduler #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 12
) (
    input logic                   clk,
    input logic                   rst_n,
    sample_tick_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, next_state;
    logic [DIV_W-1:0] div, period_cnt;
    logic [CNT_W-1:0] len, tick_cnt, tick_cnt_next;
    logic             stop_pend;
    logic             armed;
    logic             handshake, period_end, last_tick, end_burst;

    assign tick_cnt_next  = tick_cnt + CNT_W'(1);
    assign bus.tick_count = tick_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        handshake     = 1'b0;
        period_end    = 1'b0;
        last_tick     = 1'b0;
        end_burst     = 1'b0;
        bus.cfg_ready = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.tick      = 1'b0;
        bus.sclk      = 1'b0;
        case (state)
            IDLE: begin
                // armed keeps ready low until the first edge after reset release
                bus.cfg_ready = armed;
                handshake     = armed && bus.cfg_valid;
                if (handshake) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                bus.busy   = 1'b1;
                period_end = (period_cnt == div - DIV_W'(1));
                bus.tick   = period_end;
                bus.sclk   = (period_cnt >= (div >> 1));
                last_tick  = (len != '0) && (tick_cnt_next == len);
                end_burst  = period_end && (bus.stop || stop_pend || last_tick);
                if (end_burst) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                bus.busy   = 1'b1;
                bus.done   = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div        <= DIV_W'(2);
            len        <= '0;
            period_cnt <= '0;
            tick_cnt   <= '0;
            stop_pend  <= 1'b0;
            armed      <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (handshake) begin
                // divisors below 2 cannot form a low and a high phase
                div        <= (bus.cfg_div < DIV_W'(2)) ? DIV_W'(2) : bus.cfg_div;
                len        <= bus.cfg_len;
                period_cnt <= '0;
                tick_cnt   <= '0;
                stop_pend  <= 1'b0;
            end else if (state == RUN) begin
                period_cnt <= period_end ? '0 : period_cnt + DIV_W'(1);
                if (period_end) begin
                    tick_cnt <= tick_cnt_next;
                end
                if (end_burst) begin
                    stop_pend <= 1'b0;
                end else if (bus.stop) begin
                    stop_pend <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sample_tick_scheduler.sv
// Self-checking bench for sample_tick_scheduler: expected tick/done events are queued
// when a burst is configured and popped as the scheduler produces them.
module tb_sample_tick_scheduler;
    localparam int DIV_W = 16;
    localparam int CNT_W = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sample_tick_scheduler_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

    sample_tick_scheduler #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int rel;
        bit is_done;
        int count;
    } event_t;

    event_t exp_q[$];
    int     n_compared   = 0;
    int     n_mismatched = 0;

    function automatic logic [CNT_W+4:0] all_outputs();
        return {bus.cfg_ready, bus.sclk, bus.tick, bus.busy, bus.done, bus.tick_count};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // rel counts clock edges after the handshake edge; tick n is visible at rel n*d-1
    task automatic run_burst(input string name, input int cdiv, input int clen,
                             input int n_exp, input int stop_rel, input bit hold_valid);
        int     d;
        int     last_rel;
        bit     exp_sclk;
        event_t ev;
        d        = (cdiv < 2) ? 2 : cdiv;
        last_rel = n_exp * d;
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = DIV_W'(cdiv);
        bus.cfg_len   = CNT_W'(clen);
        n_compared++;
        if (bus.cfg_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL %s_ready: got %b, want 1", name, bus.cfg_ready);
        end
        for (int n = 1; n <= n_exp; n++) begin
            exp_q.push_back('{rel: n * d - 1, is_done: 1'b0, count: n - 1});
        end
        exp_q.push_back('{rel: last_rel, is_done: 1'b1, count: n_exp});
        step();
        for (int rel = 0; rel <= last_rel + 1; rel++) begin
            if (rel == 0) begin
                if (!hold_valid) bus.cfg_valid = 1'b0;
                n_compared++;
                if (bus.busy !== 1'b1 || bus.cfg_ready !== 1'b0) begin
                    n_mismatched++;
                    $display("[TB] FAIL %s_start: got busy=%b ready=%b, want busy=1 ready=0",
                             name, bus.busy, bus.cfg_ready);
                end
            end
            if (rel == 1) begin
                bus.cfg_div = DIV_W'(cdiv + 3);
                bus.cfg_len = CNT_W'(clen + 1);
            end
            bus.stop = (rel == stop_rel);
            exp_sclk = (rel < last_rel) && ((rel % d) >= d / 2);
            n_compared++;
            if (bus.sclk !== exp_sclk) begin
                n_mismatched++;
                $display("[TB] FAIL %s_sclk rel=%0d: got %b, want %b", name, rel, bus.sclk, exp_sclk);
            end
            if (bus.tick === 1'b1 || bus.done === 1'b1) begin
                n_compared++;
                if (exp_q.size() == 0) begin
                    n_mismatched++;
                    $display("[TB] FAIL %s_event rel=%0d: got tick=%b done=%b, want none",
                             name, rel, bus.tick, bus.done);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.rel != rel || ev.is_done != bus.done || ev.count != int'(bus.tick_count)) begin
                        n_mismatched++;
                        $display("[TB] FAIL %s_event: got rel=%0d done=%b count=%0d, want rel=%0d done=%b count=%0d",
                                 name, rel, bus.done, bus.tick_count, ev.rel, ev.is_done, ev.count);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].rel == rel) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL %s_missing rel=%0d: got no event, want done=%b",
                         name, rel, exp_q[0].is_done);
                void'(exp_q.pop_front());
            end
            if (rel < last_rel + 1) step();
        end
        bus.stop = 1'b0;
        n_compared++;
        if (bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1 || int'(bus.tick_count) != n_exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s_end: got busy=%b ready=%b count=%0d, want busy=0 ready=1 count=%0d",
                     name, bus.busy, bus.cfg_ready, bus.tick_count, n_exp);
        end
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL %s_leftover: got %0d pending events, want 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        bus.cfg_valid = 1'b0;
        bus.cfg_div   = '0;
        bus.cfg_len   = '0;
        bus.stop      = 1'b0;
        rst_n         = 1'b0;
        step();
        step();
        n_compared++;
        if (all_outputs() !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_outputs: got %h, want 0", all_outputs());
        end
        rst_n = 1'b1;
        #1;
        n_compared++;
        if (bus.cfg_ready !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_release_ready: got %b, want 0", bus.cfg_ready);
        end
        step();
        n_compared++;
        if (bus.cfg_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_first_edge: got ready=%b busy=%b, want ready=1 busy=0",
                     bus.cfg_ready, bus.busy);
        end
    endtask

    task automatic test_basic();
        run_burst("basic", 4, 3, 3, -1, 1'b0);
    endtask

    task automatic test_min_div();
        run_burst("div0", 0, 3, 3, -1, 1'b0);
        run_burst("div1", 1, 2, 2, -1, 1'b0);
    endtask

    task automatic test_stop();
        run_burst("stop", 10, 0, 3, 24, 1'b0);
    endtask

    task automatic test_stop_on_last();
        run_burst("stop_last", 3, 2, 2, 5, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_burst("b2b_a", 4, 2, 2, -1, 1'b1);
        run_burst("b2b_b", 3, 1, 1, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = DIV_W'(5);
        bus.cfg_len   = '0;
        step();
        bus.cfg_valid = 1'b0;
        for (int rel = 0; rel < 6; rel++) begin
            n_compared++;
            if (bus.tick !== (rel == 4)) begin
                n_mismatched++;
                $display("[TB] FAIL rmid_tick rel=%0d: got %b, want %b", rel, bus.tick, rel == 4);
            end
            step();
        end
        rst_n = 1'b0;
        #1;
        n_compared++;
        if (all_outputs() !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL rmid_immediate: got %h, want 0", all_outputs());
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_compared++;
            if (all_outputs() !== '0) begin
                n_mismatched++;
                $display("[TB] FAIL rmid_held: got %h, want 0", all_outputs());
            end
        end
        rst_n = 1'b1;
        #1;
        n_compared++;
        if (bus.cfg_ready !== 1'b0 || bus.done !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL rmid_release: got ready=%b done=%b, want 0 0", bus.cfg_ready, bus.done);
        end
        step();
        n_compared++;
        if (bus.cfg_ready !== 1'b1 || bus.done !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL rmid_ready: got ready=%b done=%b, want 1 0", bus.cfg_ready, bus.done);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_min_div();
        test_stop();
        test_stop_on_last();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
